// File: rtl/register_bank.sv
// 64 x 32 MIPS register file: two combinational read ports, one clocked write port, r0 reads as zero.
// Optional write-to-read forwarding is enabled by defining REGBANK_BYPASS_EN.
module register_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] WriteRegister,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic [ADDR_WIDTH-1:0] ReadRegister1,
  input  logic [ADDR_WIDTH-1:0] ReadRegister2,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic                  wr_en;

  // Writes to r0 are dropped here, so r0 stays at its reset value of zero.
  assign wr_en = RegWrite && (WriteRegister != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[WriteRegister] = WriteData;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Reset and index 0 force zero on the read path, so r0 never depends on storage state.
  always_comb begin
    ReadData1 = regs_q[ReadRegister1];
    ReadData2 = regs_q[ReadRegister2];
`ifdef REGBANK_BYPASS_EN
    if (wr_en && (ReadRegister1 == WriteRegister)) begin
      ReadData1 = WriteData;
    end
    if (wr_en && (ReadRegister2 == WriteRegister)) begin
      ReadData2 = WriteData;
    end
`else
`endif
    if (reset || (ReadRegister1 == '0)) begin
      ReadData1 = '0;
    end
    if (reset || (ReadRegister2 == '0)) begin
      ReadData2 = '0;
    end
  end

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank; an array model tracks architectural register contents.
module tb_register_bank;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        RegWrite = 1'b0;
  logic [5:0]  WriteRegister = '0;
  logic [31:0] WriteData = '0;
  logic [5:0]  ReadRegister1 = '0;
  logic [5:0]  ReadRegister2 = '0;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [64];

`ifdef REGBANK_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  register_bank dut (
    .clk(clk),
    .reset(reset),
    .RegWrite(RegWrite),
    .WriteRegister(WriteRegister),
    .WriteData(WriteData),
    .ReadRegister1(ReadRegister1),
    .ReadRegister2(ReadRegister2),
    .ReadData1(ReadData1),
    .ReadData2(ReadData2)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] exp_read(input logic [5:0] a);
    if (reset || a == 6'd0) return 32'd0;
    if (BYPASS && RegWrite && WriteRegister != 6'd0 && a == WriteRegister) return WriteData;
    return model[a];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 64; i++) model[i] = 32'd0;
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) clear_model();
    else if (RegWrite && WriteRegister != 6'd0) model[WriteRegister] = WriteData;
    #1;
  endtask

  task automatic write_reg(input logic [5:0] a, input logic [31:0] d);
    RegWrite = 1'b1; WriteRegister = a; WriteData = d;
    step();
    RegWrite = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_model();
    repeat (2) step();
    reset = 1'b0;
    ReadRegister1 = 6'd0; ReadRegister2 = 6'd1;
    #1;
    checks++; if (ReadData1 !== 32'd0) begin errors++; $display("[TB] FAIL reset_r0 got %h want 0", ReadData1); end
    checks++; if (ReadData2 !== 32'd0) begin errors++; $display("[TB] FAIL reset_r1 got %h want 0", ReadData2); end
    ReadRegister1 = 6'd63;
    #1;
    checks++; if (ReadData1 !== 32'd0) begin errors++; $display("[TB] FAIL reset_r63 got %h want 0", ReadData1); end
  endtask

  task automatic test_write_disabled();
    RegWrite = 1'b0; WriteRegister = 6'd0; WriteData = 32'd100;
    repeat (5) step();
    ReadRegister1 = 6'd0;
    #1;
    checks++; if (ReadData1 !== 32'd0) begin errors++; $display("[TB] FAIL wdis_r0 got %h want 0", ReadData1); end
    RegWrite = 1'b1; WriteRegister = 6'd7; WriteData = 32'h0BAD_F00D;
    RegWrite = 1'b0;
    repeat (5) step();
    for (int i = 0; i < 64; i++) begin
      ReadRegister2 = i[5:0];
      #1;
      checks++;
      if (ReadData2 !== 32'd0) begin errors++; $display("[TB] FAIL wdis_reg%0d got %h want 0", i, ReadData2); end
    end
  endtask

  task automatic test_basic();
    write_reg(6'd1, 32'd100);
    ReadRegister1 = 6'd1; ReadRegister2 = 6'd0;
    #1;
    checks++; if (ReadData1 !== 32'd100) begin errors++; $display("[TB] FAIL basic_rd1 got %0d want 100", ReadData1); end
    checks++; if (ReadData2 !== 32'd0) begin errors++; $display("[TB] FAIL basic_rd2 got %0d want 0", ReadData2); end
  endtask

  task automatic test_reg0();
    write_reg(6'd0, 32'hDEADBEEF);
    ReadRegister1 = 6'd0;
    #1;
    checks++; if (ReadData1 !== 32'd0) begin errors++; $display("[TB] FAIL reg0_protect got %h want 0", ReadData1); end
  endtask

  task automatic test_dual_port();
    write_reg(6'd63, 32'hFFFF0001);
    write_reg(6'd2, 32'd7);
    ReadRegister1 = 6'd63; ReadRegister2 = 6'd2;
    #1;
    checks++; if (ReadData1 !== 32'hFFFF0001) begin errors++; $display("[TB] FAIL dual_r63 got %h want ffff0001", ReadData1); end
    checks++; if (ReadData2 !== 32'd7) begin errors++; $display("[TB] FAIL dual_r2 got %h want 7", ReadData2); end
    ReadRegister2 = 6'd63;
    #1;
    checks++; if (ReadData2 !== 32'hFFFF0001) begin errors++; $display("[TB] FAIL dual_same got %h want ffff0001", ReadData2); end
    ReadRegister2 = 6'd2;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (ReadData1 !== 32'd0) begin errors++; $display("[TB] FAIL midreset_rd1 got %h want 0", ReadData1); end
    checks++; if (ReadData2 !== 32'd0) begin errors++; $display("[TB] FAIL midreset_rd2 got %h want 0", ReadData2); end
    clear_model();
    step();
    reset = 1'b0;
    #1;
    checks++; if (ReadData1 !== 32'd0) begin errors++; $display("[TB] FAIL postreset_r63 got %h want 0", ReadData1); end
  endtask

  task automatic test_read_during_write();
    logic [31:0] want;
    write_reg(6'd5, 32'd10);
    RegWrite = 1'b1; WriteRegister = 6'd5; WriteData = 32'd20; ReadRegister1 = 6'd5;
    #1;
    want = BYPASS ? 32'd20 : 32'd10;
    checks++; if (ReadData1 !== want) begin errors++; $display("[TB] FAIL rdw_before got %0d want %0d", ReadData1, want); end
    step();
    RegWrite = 1'b0;
    #1;
    checks++; if (ReadData1 !== 32'd20) begin errors++; $display("[TB] FAIL rdw_after got %0d want 20", ReadData1); end
  endtask

  task automatic test_reset_vs_write();
    write_reg(6'd9, 32'h1111_2222);
    RegWrite = 1'b1; WriteRegister = 6'd9; WriteData = 32'h1234_5678; ReadRegister1 = 6'd9;
    @(negedge clk);
    #4;
    reset = 1'b1;
    #0.5;
    checks++; if (ReadData1 !== 32'd0) begin errors++; $display("[TB] FAIL reset_blocks_fwd got %h want 0", ReadData1); end
    step();
    reset = 1'b0;
    RegWrite = 1'b0;
    #1;
    checks++; if (ReadData1 !== 32'd0) begin errors++; $display("[TB] FAIL reset_wins got %h want 0", ReadData1); end
    write_reg(6'd9, 32'hCAFE_0009);
    #1;
    checks++; if (ReadData1 !== 32'hCAFE_0009) begin errors++; $display("[TB] FAIL first_write_after_reset got %h want cafe0009", ReadData1); end
  endtask

  task automatic test_random();
    logic [31:0] e1, e2;
    for (int n = 0; n < 400; n++) begin
      RegWrite = ($urandom_range(0, 3) != 0);
      WriteRegister = 6'($urandom_range(0, 63));
      WriteData = $urandom;
      ReadRegister1 = ($urandom_range(0, 3) == 0) ? WriteRegister : 6'($urandom_range(0, 63));
      ReadRegister2 = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(0, 63));
      #1;
      e1 = exp_read(ReadRegister1); e2 = exp_read(ReadRegister2);
      checks++; if (ReadData1 !== e1) begin errors++; $display("[TB] FAIL rand_pre_rd1 idx %0d got %h want %h", ReadRegister1, ReadData1, e1); end
      checks++; if (ReadData2 !== e2) begin errors++; $display("[TB] FAIL rand_pre_rd2 idx %0d got %h want %h", ReadRegister2, ReadData2, e2); end
      step();
      e1 = exp_read(ReadRegister1); e2 = exp_read(ReadRegister2);
      checks++; if (ReadData1 !== e1) begin errors++; $display("[TB] FAIL rand_post_rd1 idx %0d got %h want %h", ReadRegister1, ReadData1, e1); end
      checks++; if (ReadData2 !== e2) begin errors++; $display("[TB] FAIL rand_post_rd2 idx %0d got %h want %h", ReadRegister2, ReadData2, e2); end
    end
    RegWrite = 1'b0;
    for (int i = 0; i < 64; i++) begin
      ReadRegister1 = i[5:0];
      #1;
      e1 = (i == 0) ? 32'd0 : model[i];
      checks++; if (ReadData1 !== e1) begin errors++; $display("[TB] FAIL rand_sweep reg%0d got %h want %h", i, ReadData1, e1); end
    end
  endtask

  initial begin
    clear_model();
    test_reset();
    test_write_disabled();
    test_basic();
    test_reg0();
    test_dual_port();
    test_read_during_write();
    test_reset_vs_write();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
